// File: rtl/mux_rr_sequencer_4ch.sv
// rtl/mux_rr_sequencer_4ch.sv - round-robin 4-channel sequencer driving an n-bit 4:1 mux
//
// Arbitrates four level-sensitive requesters, drives the mux select, captures
// the selected mux word and hands it downstream over valid/ready.
//
// Ports:
//   clk_in     rising-edge clock
//   reset_in   synchronous active-high reset
//   req_in     [3:0] per-channel request, held until the channel's grant pulse
//   mux_f_in   [n-1:0] mux output, combinational from s_out
//   s_out      [1:0] registered mux select
//   grant_out  [3:0] one-hot, one-cycle pulse for the captured channel
//   data_out   [n-1:0] registered captured word
//   valid_out  data_out holds an unconsumed word
//   ready_in   downstream accepts data_out when valid_out && ready_in

module mux_rr_sequencer_4ch #(
  parameter int n = 4
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic [3:0]   req_in,
  input  logic [n-1:0] mux_f_in,
  output logic [1:0]   s_out,
  output logic [3:0]   grant_out,
  output logic [n-1:0] data_out,
  output logic         valid_out,
  input  logic         ready_in
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   s_q, s_d;
  logic [1:0]   last_q, last_d;
  logic [3:0]   grant_q, grant_d;
  logic [n-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  logic [3:0]   pick_req;
  logic [1:0]   win;
  logic         found;
  logic [1:0]   idx;

  // Round-robin scan starting just after the last served channel. In OUTPUT
  // the just-granted channel is masked because its source may still be
  // holding the request it was served for.
  always_comb begin
    pick_req = req_in;
    if (state_q == OUTPUT) begin
      pick_req = req_in & ~(4'b0001 << last_q);
    end
    win   = last_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && pick_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    grant_d = 4'b0000;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          s_d     = win;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Pick is committed: capture even if the request has since dropped.
        data_d  = mux_f_in;
        valid_d = 1'b1;
        grant_d = 4'b0001 << s_q;
        last_d  = s_q;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (valid_q && ready_in) begin
          valid_d = 1'b0;
          if (found) begin
            s_d     = win;
            state_d = CAPTURE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      s_q     <= 2'd0;
      last_q  <= 2'd3;
      grant_q <= 4'b0000;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign s_out     = s_q;
  assign grant_out = grant_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_rr_sequencer_4ch.sv
// tb/tb_mux_rr_sequencer_4ch.sv - self-checking bench for mux_rr_sequencer_4ch

module tb_mux_rr_sequencer_4ch;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] mux_f;
  logic [1:0] s;
  logic [3:0] grant;
  logic [3:0] data;
  logic       valid;
  logic       ready;

  logic [3:0] words [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_f = words[s];

  mux_rr_sequencer_4ch #(.n(4)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .req_in   (req),
    .mux_f_in (mux_f),
    .s_out    (s),
    .grant_out(grant),
    .data_out (data),
    .valid_out(valid),
    .ready_in (ready)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] s;
    logic [3:0] g;
    logic       v;
    logic [3:0] d;
  } vec_t;

  vec_t tbl [31];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic rd);
    rst   = r;
    req   = q;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  // Reference model: transaction phases and modulo-4 pointer arithmetic.
  int         m_phase;   // 0 waiting, 1 select loaded, 2 word held
  int         m_last;
  int         m_s;
  logic [3:0] m_grant;
  logic [3:0] m_data;
  logic       m_valid;

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] q, input logic rd);
    int w;
    if (r) begin
      m_phase = 0; m_last = 3; m_s = 0; m_grant = 0; m_data = 0; m_valid = 0;
      return;
    end
    m_grant = 4'b0000;
    if (m_phase == 0) begin
      w = rr_pick(q, m_last);
      if (w >= 0) begin m_s = w; m_phase = 1; end
    end else if (m_phase == 1) begin
      m_data  = words[m_s];
      m_valid = 1'b1;
      m_grant = 4'(1 << m_s);
      m_last  = m_s;
      m_phase = 2;
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
      w = rr_pick(q & ~4'(1 << m_last), m_last);
      if (w >= 0) begin m_s = w; m_phase = 1; end
      else m_phase = 0;
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'h0; ready = 1'b1;
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3; words[3] = 4'h4;

    //            rst req  rdy  s  grant  v  d
    tbl[0]  = '{1'b1, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 2'd0, 4'h1, 1'b1, 4'h1};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 2'd1, 4'h0, 1'b0, 4'h1};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 2'd1, 4'h2, 1'b1, 4'h2};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 2'd2, 4'h0, 1'b0, 4'h2};
    tbl[6]  = '{1'b0, 4'hF, 1'b1, 2'd2, 4'h4, 1'b1, 4'h3};
    tbl[7]  = '{1'b0, 4'hF, 1'b1, 2'd3, 4'h0, 1'b0, 4'h3};
    tbl[8]  = '{1'b0, 4'hF, 1'b1, 2'd3, 4'h8, 1'b1, 4'h4};
    tbl[9]  = '{1'b0, 4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 4'h4};
    tbl[10] = '{1'b0, 4'hF, 1'b1, 2'd0, 4'h1, 1'b1, 4'h1};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 4'h1};
    tbl[12] = '{1'b0, 4'h4, 1'b0, 2'd2, 4'h0, 1'b0, 4'h1};
    tbl[13] = '{1'b0, 4'h4, 1'b0, 2'd2, 4'h4, 1'b1, 4'h3};
    tbl[14] = '{1'b0, 4'h4, 1'b0, 2'd2, 4'h0, 1'b1, 4'h3};
    tbl[15] = '{1'b0, 4'h4, 1'b0, 2'd2, 4'h0, 1'b1, 4'h3};
    tbl[16] = '{1'b0, 4'h4, 1'b0, 2'd2, 4'h0, 1'b1, 4'h3};
    tbl[17] = '{1'b0, 4'h4, 1'b0, 2'd2, 4'h0, 1'b1, 4'h3};
    tbl[18] = '{1'b0, 4'h0, 1'b1, 2'd2, 4'h0, 1'b0, 4'h3};
    tbl[19] = '{1'b0, 4'h2, 1'b0, 2'd1, 4'h0, 1'b0, 4'h3};
    tbl[20] = '{1'b0, 4'h2, 1'b0, 2'd1, 4'h2, 1'b1, 4'h2};
    tbl[21] = '{1'b0, 4'h3, 1'b1, 2'd0, 4'h0, 1'b0, 4'h2};
    tbl[22] = '{1'b0, 4'h3, 1'b1, 2'd0, 4'h1, 1'b1, 4'h1};
    tbl[23] = '{1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 4'h1};
    tbl[24] = '{1'b0, 4'h8, 1'b0, 2'd3, 4'h0, 1'b0, 4'h1};
    tbl[25] = '{1'b0, 4'h0, 1'b0, 2'd3, 4'h8, 1'b1, 4'h4};
    tbl[26] = '{1'b0, 4'h0, 1'b0, 2'd3, 4'h0, 1'b1, 4'h4};
    tbl[27] = '{1'b1, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    tbl[28] = '{1'b0, 4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 4'h0};
    tbl[29] = '{1'b0, 4'hF, 1'b1, 2'd0, 4'h1, 1'b1, 4'h1};
    tbl[30] = '{1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 4'h1};

    for (int i = 0; i < 31; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].rdy);
      check($sformatf("vec%0d_s", i),     s,     tbl[i].s);
      check($sformatf("vec%0d_grant", i), grant, tbl[i].g);
      check($sformatf("vec%0d_valid", i), valid, tbl[i].v);
      check($sformatf("vec%0d_data", i),  data,  tbl[i].d);
    end

    // Reset then single request with 0xA on ch0.
    words[0] = 4'hA;
    step(1'b1, 4'h0, 1'b1);
    check("single_reset_valid", valid, 0);
    step(1'b0, 4'h1, 1'b1);
    check("single_s_edge1", s, 0);
    check("single_valid_edge1", valid, 0);
    step(1'b0, 4'h1, 1'b1);
    check("single_data_edge2", data, 4'hA);
    check("single_valid_edge2", valid, 1);
    check("single_grant_edge2", grant, 4'h1);
    step(1'b0, 4'h0, 1'b1);
    check("single_valid_edge3", valid, 0);
    check("single_grant_edge3", grant, 0);

    // Randomized run against the reference model.
    step(1'b1, 4'h0, 1'b1);
    model_edge(1'b1, 4'h0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      logic       r_rst;
      logic [3:0] r_req;
      logic       r_rdy;
      r_rst = ($urandom_range(0, 99) == 0);
      r_req = 4'($urandom_range(0, 15));
      r_rdy = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 4; k++) words[k] = 4'($urandom_range(0, 15));
      model_edge(r_rst, r_req, r_rdy);
      step(r_rst, r_req, r_rdy);
      check($sformatf("rand%0d_s", c),     s,     m_s);
      check($sformatf("rand%0d_grant", c), grant, m_grant);
      check($sformatf("rand%0d_valid", c), valid, m_valid);
      check($sformatf("rand%0d_data", c),  data,  m_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_sequencer_4ch.md
# mux_rr_sequencer_4ch

Round-robin sequencer that sits directly upstream of the n-bit 4:1 mux. It arbitrates among four requesting sources and drives the mux select. It captures the selected word from the mux output into a register and hands that word downstream over a valid/ready handshake. It also returns a one-cycle grant pulse to the source that was served.

## Interface
- n, default 4: data width; must match the mux width.
- clk_in  input  1  rising-edge clock.
- reset_in  input  1  synchronous reset, active-high.
- req_in  input  4  per-channel request, level-sensitive. The source holds it until it sees its grant pulse.
- mux_f_in  input  n  mux output, combinational from s_out.
- s_out  output  2  registered select that drives the mux s_in.
- grant_out  output  4  one-hot, one-cycle pulse marking the channel whose word was captured.
- data_out  output  n  registered captured word.
- valid_out  output  1  data_out holds an unconsumed word.
- ready_in  input  1  downstream accepts data_out when valid_out && ready_in.

## Operation
- Reset values: s_out=0, grant_out=0, data_out=0, valid_out=0, state=IDLE, last pointer=3. With last=3, ch0 has first priority.
- Round-robin pick: scan the channels last+1, last+2, last+3, last, modulo 4. The first channel with req_in set wins. The 2-bit index wraps 3->0.
- State IDLE: if req_in is nonzero, load s_out with the winner and go to CAPTURE. If req_in is zero, stay in IDLE and hold s_out.
- State CAPTURE: s_out is stable, so mux_f_in is valid. On the clock edge:
  - data_out <= mux_f_in
  - valid_out <= 1
  - grant_out <= one-hot(s_out) for exactly one cycle
  - last <= s_out
  - go to OUTPUT.
- The pick is committed once the block enters CAPTURE. If req_in of the chosen channel drops during CAPTURE, the capture still happens and the grant still pulses.
- State OUTPUT: grant_out returns to 0 after its single cycle. data_out and valid_out hold until valid_out && ready_in. On that handshake cycle:
  - valid_out <= 0
  - if req_in, masked by the grant issued this transaction, is nonzero, load s_out with the new round-robin winner and go straight to CAPTURE
  - otherwise go to IDLE.
- The just-granted channel's req_in is ignored for exactly one pick, because its source may not yet have dropped it.
- s_out changes only on a transition into CAPTURE. At all other times it holds, so the downstream mux output is stable.
- data_out never changes while valid_out=1.
- Arithmetic: the pointer and select are 2-bit and wrap naturally. No width extension of the data path.

## Timing
- Latency: req_in first sampled high in IDLE at edge k.
  - s_out updates at edge k.
  - data_out, valid_out and grant_out update at edge k+1.
- Back-to-back throughput: one word per 2 cycles when ready_in is held high. The handshake edge also loads the next s_out; the next edge captures.
- ready_in=0 stalls the block indefinitely in OUTPUT. Requests are not lost during the stall; they are re-evaluated at the handshake.
- reset_in has priority in any state, including mid-CAPTURE and mid-OUTPUT. All registers take their reset values at that edge, and any held word is discarded.
- Simultaneous requests on all four channels with ready_in=1: the grant order is ch0, ch1, ch2, ch3, ch0, and so on.

## Test plan
- Reset then single request: with n=4, reset, then req_in=0001 and mux_f_in=0xA. Required: s_out=0 after 1 edge, then data_out=0xA, valid_out=1 and grant_out=0001 after 2 edges. With ready_in=1, valid_out drops on the next edge.
- Round-robin fairness: hold req_in=1111, ready_in=1, and model the mux with words 0x1, 0x2, 0x3, 0x4 on inputs 0-3. Required: data_out sequence 1,2,3,4,1, grant_out sequence 0001,0010,0100,1000,0001, and valid_out asserted every 2nd cycle.
- Backpressure: req_in=0100, ready_in=0 for 5 cycles, then 1. Required: valid_out=1 and data_out stable throughout, s_out=2 held, and exactly one grant pulse.
- Late-arriving competitor: ch1 is being served; req_in=0010 changes to 0011 during OUTPUT. Required: ch0 is granted next, with the ch1 request ignored for that pick.
- Request withdrawn: req_in=1000 for 1 cycle only. Required: the capture still occurs, grant_out=1000 and valid_out=1.
- Mid-operation reset: assert reset_in while in OUTPUT with valid_out=1. Required: on the next edge all outputs are 0 and the next req_in=1111 grants ch0 first.
